// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: operation codes and FSM state type.
// Optional multiply support is enabled by defining ALU_EXEC_MUL_EN.
`timescale 1ns/1ps

package alu_pkg;

    // Operation codes delivered by the ALU control stage
    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_OR   = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_SLT  = 4'b0111;
    localparam logic [3:0] CTL_MUL  = 4'b1000;
    localparam logic [3:0] CTL_NOR  = 4'b1100;
    localparam logic [3:0] CTL_SLL  = 4'b1110;
    localparam logic [3:0] CTL_PASS = 4'b1111;

    // Execute-stage sequencing: single-cycle ops never leave IDLE
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
// start loads operands; DATA_W iterations follow. done is high during the
// cycle of the final iteration, with product already showing the final sum,
// so the consumer can capture it on that same edge.
// Only instantiated when ALU_EXEC_MUL_EN is defined.
`timescale 1ns/1ps

module alu_mul_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int                CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;
    logic [DATA_W-1:0] partial;
    logic [DATA_W-1:0] sum;

    // Add the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        partial = mplier_q[0] ? mcand_q : '0;
        sum     = acc_q + partial;
    end

    // Next-state: load on start, otherwise shift one bit per cycle while running
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = sum;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                run_d = 1'b0;
            end
        end
    end

    assign done    = run_q && (cnt_q == LAST);
    assign product = sum;

    // Datapath and iteration counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage with valid/ready handshake on both sides and a single
// registered output slot. Single-cycle ops appear one edge after acceptance.
// Define ALU_EXEC_MUL_EN to add code 1000 as an iterative unsigned multiply
// (busy while it runs); without it, code 1000 is reported as illegal.
`timescale 1ns/1ps

module alu_exec_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        control,
    input  logic              jr,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [4:0]        shamt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              jr_out,
    output logic              illegal,
    output logic              busy
);

    import alu_pkg::*;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              jr_out_q, jr_out_d;
    logic              illegal_q, illegal_d;

    logic [DATA_W-1:0] alu_res;
    logic              alu_legal;
    logic              accept;

`ifdef ALU_EXEC_MUL_EN
    alu_state_e        state_q, state_d;
    logic              mul_start;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    alu_mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (rs_val),
        .b       (rt_val),
        .done    (mul_done),
        .product (mul_product)
    );

    assign busy = (state_q == ST_MUL);
`else
    assign busy = 1'b0;
`endif

    // A slot is free when nothing is held or the held result leaves this edge
    assign in_ready  = !busy && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign jr_out    = jr_out_q;
    assign illegal   = illegal_q;

    // Single-cycle operation decode; unknown codes give 0 and flag illegal
    always_comb begin
        alu_res   = '0;
        alu_legal = 1'b1;
        case (control)
            CTL_ADD:  alu_res = rs_val + rt_val;
            CTL_SUB:  alu_res = rs_val - rt_val;
            CTL_AND:  alu_res = rs_val & rt_val;
            CTL_OR:   alu_res = rs_val | rt_val;
            CTL_NOR:  alu_res = ~(rs_val | rt_val);
            CTL_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(rs_val) < $signed(rt_val))};
            CTL_SLL:  alu_res = rt_val << shamt;
            CTL_PASS: alu_res = rs_val;
            default: begin
                alu_res   = '0;
                alu_legal = 1'b0;
            end
        endcase
    end

    // Output slot and sequencing: drain on transfer, refill on accept or multiply completion
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        jr_out_d    = jr_out_q;
        illegal_d   = illegal_q;
`ifdef ALU_EXEC_MUL_EN
        state_d     = state_q;
        mul_start   = 1'b0;
`endif
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            jr_out_d = jr;
`ifdef ALU_EXEC_MUL_EN
            if (control == CTL_MUL) begin
                mul_start = 1'b1;
                state_d   = ST_MUL;
            end else
`endif
            begin
                result_d    = alu_res;
                zero_d      = (alu_res == '0);
                illegal_d   = !alu_legal;
                out_valid_d = 1'b1;
            end
        end
`ifdef ALU_EXEC_MUL_EN
        if ((state_q == ST_MUL) && mul_done) begin
            result_d    = mul_product;
            zero_d      = (mul_product == '0);
            illegal_d   = 1'b0;
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
        end
`endif
    end

    // Output and state registers; reset aborts any multiply in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            jr_out_q    <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            state_q     <= ST_IDLE;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            jr_out_q    <= jr_out_d;
            illegal_q   <= illegal_d;
`ifdef ALU_EXEC_MUL_EN
            state_q     <= state_d;
`endif
        end
    end

endmodule
